sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Arbitrates the instruction-fetch port and the data-access port of the CPU core onto a single shared SRAM-like memory port, with one transaction outstanding at a time. It sits between the IF/MEM stages and the external memory bridge. It latches the winning request, sequences it through the address and data phases of the shared port, and routes the response back to the requester that issued it.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `inst_req` in 1: instruction request.
- `inst_wr` in 1: write enable.
- `inst_size` in 2: access size.
- `inst_addr` in ADDR_W.
- `inst_wdata` in DATA_W.
- `inst_addr_ok` out 1: request accepted.
- `inst_data_ok` out 1: response valid.
- `inst_rdata` out DATA_W.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `data_addr_ok`, `data_data_ok`, `data_rdata`: same widths and meanings as the `inst_*` ports.
- `mem_req` out 1.
- `mem_wr` out 1.
- `mem_size` out 2.
- `mem_addr` out ADDR_W.
- `mem_wdata` out DATA_W.
- `mem_addr_ok` in 1.
- `mem_data_ok` in 1.
- `mem_rdata` in DATA_W.

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE**
  - If `inst_req` or `data_req` is high, pick a winner.
  - Pulse the winner's `*_addr_ok` in that same cycle.
  - Latch `grant`, `wr`, `size`, `addr` and `wdata` from the winner.
  - Go to ADDR.
  - The loser gets no `addr_ok` and must hold its request.
- **ADDR**
  - `mem_req`=1; `mem_*` fields are driven from the latched registers.
  - On `mem_addr_ok`, go to DATA.
  - `mem_data_ok` is ignored in this state.
- **DATA**
  - `mem_req`=0.
  - On `mem_data_ok`, assert the granted master's `*_data_ok` combinationally in the same cycle, with `*_rdata`=`mem_rdata`.
  - Then go to IDLE.
- Arbitration without the macro: fixed priority, data over inst.
- The non-granted master's `data_ok` is always 0.
- `*_rdata` outputs are don't-care when the matching `data_ok`=0; drive `mem_rdata` to both.
- Writes follow the same flow; the master's `data_ok` marks write completion.
- No new request is accepted in ADDR or DATA; all `*_addr_ok` are 0 in those states.

## Timing
- Reset values:
  - state=IDLE.
  - `mem_req`=0.
  - `mem_wr`=0, `mem_size`=0, `mem_addr`=0, `mem_wdata`=0.
  - All `*_addr_ok` and `*_data_ok`=0.
  - `grant`=inst.
- Minimum transaction timing: request accepted at cycle 0, `mem_req` at cycle 1, `mem_addr_ok` at cycle 1, `mem_data_ok` at cycle 2 gives master `data_ok` at cycle 2.
- IDLE is re-entered at cycle 3, where the next request can be accepted. Back-to-back throughput is one transaction per 3 cycles minimum.
- `mem_*` outputs are registered; master `addr_ok`/`data_ok` are combinational.
- Simultaneous inst and data requests in IDLE: exactly one wins, as defined in Configuration.
- Reset mid-transaction returns to IDLE next cycle and drops the outstanding response. A later stray `mem_data_ok` in IDLE is ignored.
- `mem_addr_ok` and `mem_data_ok` in IDLE are ignored.

## Configuration
- `SRAM_ARB_RR_EN` defined:
  - On a simultaneous request, round-robin arbitration grants the master that did not win the previous arbitration.
  - A `last_grant` register resets to inst, so data wins the first tie.
  - A lone request is always granted.
- `SRAM_ARB_RR_EN` undefined: fixed priority, data over inst, with no `last_grant` register.

## Structure
- Shared header `mycpu.h` holds:
  - state encodings `SARB_IDLE`/`SARB_ADDR`/`SARB_DATA`;
  - `SARB_GNT_INST`/`SARB_GNT_DATA`;
  - `SARB_SIZE_W`.
- One natural sub-module: `sram_arb_pick`, the combinational winner select from the two request bits and `last_grant`, with the RR/fixed choice under the macro.

## Test plan
- Lone `inst_req`, addr 0xbfc00000, slave `addr_ok` at +1 and `data_ok` at +2 with rdata 0x3c080001:
  - `inst_addr_ok` at cycle 0;
  - `mem_addr`=0xbfc00000 at cycle 1;
  - `inst_data_ok` with rdata 0x3c080001 at cycle 2;
  - `data_data_ok` never asserted.
- Both requesting at cycle 0, data write to 0x80000010 with wdata 0x12345678:
  - data granted first and `mem_wr`=1;
  - inst accepted on the first IDLE after data's `data_ok`.
  - With `SRAM_ARB_RR_EN` and both held continuously, grants alternate data, inst, data, inst.
- Slave stalls `mem_addr_ok` for 5 cycles:
  - `mem_req` and fields held stable;
  - no `addr_ok` to the second requester meanwhile.
- Slave asserts `mem_data_ok` during ADDR or IDLE: ignored, with no master `data_ok` and no state change.
- `reset` asserted while in DATA: state=IDLE and all outputs at reset values next cycle; a subsequent `mem_data_ok` is ignored.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the SRAM-like port arbiter: FSM states, grant ids, size width.
// The optional round-robin arbitration is selected with the SRAM_ARB_RR_EN macro.
package sram_like_arbiter_pkg;

    localparam int SARB_SIZE_W = 2;

    typedef enum logic [1:0] {
        SARB_IDLE = 2'd0,
        SARB_ADDR = 2'd1,
        SARB_DATA = 2'd2
    } sarb_state_e;

    typedef enum logic {
        SARB_GNT_INST = 1'b0,
        SARB_GNT_DATA = 1'b1
    } sarb_gnt_e;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// SRAM-like request/response bus; master drives the request, slave answers with addr_ok/data_ok.
interface sram_like_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import sram_like_arbiter_pkg::*;

    logic                   req;
    logic                   wr;
    logic [SARB_SIZE_W-1:0] size;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      wdata;
    logic                   addr_ok;
    logic                   data_ok;
    logic [DATA_W-1:0]      rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_arb_pick.sv
// Combinational winner select between the inst and data requesters.
// With SRAM_ARB_RR_EN a tie goes to the master that lost the previous arbitration.
module sram_arb_pick
    import sram_like_arbiter_pkg::*;
(
    output sarb_gnt_e winner,
    input  logic      inst_req,
    input  logic      data_req
`ifdef SRAM_ARB_RR_EN
    ,
    input  sarb_gnt_e last_grant
`endif
);

    // Winner selection; only meaningful when at least one request is high
    always_comb begin
        winner = SARB_GNT_INST;
`ifdef SRAM_ARB_RR_EN
        if (inst_req && data_req) begin
            winner = (last_grant == SARB_GNT_INST) ? SARB_GNT_DATA : SARB_GNT_INST;
        end else if (data_req) begin
            winner = SARB_GNT_DATA;
        end else begin
            winner = SARB_GNT_INST;
        end
`else
        if (data_req) begin
            winner = SARB_GNT_DATA;
        end else begin
            winner = SARB_GNT_INST;
        end
`endif
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access, one
// transaction in flight. Optional round-robin tie-break under SRAM_ARB_RR_EN.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_like_arbiter_if.slave   inst,
    sram_like_arbiter_if.slave   data,
    sram_like_arbiter_if.master  mem
);

    sarb_state_e            state_r;
    sarb_gnt_e              grant_r;
    sarb_gnt_e              win_s;
    logic                   mem_req_r;
    logic                   mem_wr_r;
    logic [SARB_SIZE_W-1:0] mem_size_r;
    logic [ADDR_W-1:0]      mem_addr_r;
    logic [DATA_W-1:0]      mem_wdata_r;
    logic                   take_s;
    logic                   resp_s;
`ifdef SRAM_ARB_RR_EN
    sarb_gnt_e              last_grant_r;
`endif

    sram_arb_pick u_pick (
        .winner     (win_s),
        .inst_req   (inst.req),
        .data_req   (data.req)
`ifdef SRAM_ARB_RR_EN
        ,
        .last_grant (last_grant_r)
`endif
    );

    assign take_s = (state_r == SARB_IDLE) && (inst.req || data.req);
    assign resp_s = (state_r == SARB_DATA) && mem.data_ok;

    assign inst.addr_ok = take_s && (win_s == SARB_GNT_INST);
    assign data.addr_ok = take_s && (win_s == SARB_GNT_DATA);
    assign inst.data_ok = resp_s && (grant_r == SARB_GNT_INST);
    assign data.data_ok = resp_s && (grant_r == SARB_GNT_DATA);
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;

    assign mem.req   = mem_req_r;
    assign mem.wr    = mem_wr_r;
    assign mem.size  = mem_size_r;
    assign mem.addr  = mem_addr_r;
    assign mem.wdata = mem_wdata_r;

    // Transaction FSM with registered memory-side request fields
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= SARB_IDLE;
            grant_r      <= SARB_GNT_INST;
            mem_req_r    <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_size_r   <= {SARB_SIZE_W{1'b0}};
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
`ifdef SRAM_ARB_RR_EN
            last_grant_r <= SARB_GNT_INST;
`endif
        end else begin
            case (state_r)
                SARB_IDLE: begin
                    if (take_s) begin
                        grant_r   <= win_s;
`ifdef SRAM_ARB_RR_EN
                        last_grant_r <= win_s;
`endif
                        mem_req_r <= 1'b1;
                        state_r   <= SARB_ADDR;
                        if (win_s == SARB_GNT_DATA) begin
                            mem_wr_r    <= data.wr;
                            mem_size_r  <= data.size;
                            mem_addr_r  <= data.addr;
                            mem_wdata_r <= data.wdata;
                        end else begin
                            mem_wr_r    <= inst.wr;
                            mem_size_r  <= inst.size;
                            mem_addr_r  <= inst.addr;
                            mem_wdata_r <= inst.wdata;
                        end
                    end
                end
                SARB_ADDR: begin
                    if (mem.addr_ok) begin
                        mem_req_r <= 1'b0;
                        state_r   <= SARB_DATA;
                    end
                end
                SARB_DATA: begin
                    if (mem.data_ok) begin
                        state_r <= SARB_IDLE;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    state_r   <= SARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: stimulus pushes expected responses, a negedge
// monitor pops them whenever a master data_ok appears.
module tb_sram_like_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   passed;

    typedef struct packed {
        logic        who;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
    sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
    sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_if),
        .data  (data_if),
        .mem   (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic run_both(input int k);
        logic exp_who;
        inst_if.req   = 1'b1;
        inst_if.wr    = 1'b0;
        inst_if.addr  = 32'hbfc00100;
        data_if.req   = 1'b1;
        data_if.wr    = 1'b0;
        data_if.addr  = 32'h80000100;
`ifdef SRAM_ARB_RR_EN
        exp_who = (k % 2 == 0) ? 1'b1 : 1'b0;
`else
        exp_who = 1'b1;
`endif
        smp();
        chk1("both_data_addr_ok", data_if.addr_ok, exp_who);
        chk1("both_inst_addr_ok", inst_if.addr_ok, ~exp_who);
        exp_q.push_back('{who: exp_who, rdata: 32'h00001000 + 32'(k)});
        nxt();
        mem_if.addr_ok = 1'b1;
        smp();
        chk("both_mem_addr", mem_if.addr, exp_who ? 32'h80000100 : 32'hbfc00100);
        nxt();
        mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = 32'h00001000 + 32'(k);
        smp();
        nxt();
        mem_if.data_ok = 1'b0;
    endtask

    // Response monitor: every master data_ok must match the oldest expected response
    always @(negedge clk) begin
        if (inst_if.data_ok === 1'b1 || data_if.data_ok === 1'b1) begin
            exp_t e;
            logic who;
            logic [31:0] rd;
            checks++;
            who = data_if.data_ok;
            rd  = who ? data_if.rdata : inst_if.rdata;
            if (inst_if.data_ok === 1'b1 && data_if.data_ok === 1'b1) begin
                $display("FAIL resp_both: got both data_ok expected one");
            end else if (exp_q.size() == 0) begin
                $display("FAIL resp_unexpected: got data_ok who=%b rdata=%h expected none", who, rd);
            end else begin
                e = exp_q.pop_front();
                if (who == e.who && rd == e.rdata) passed++;
                else $display("FAIL resp: got who=%b rdata=%h expected who=%b rdata=%h",
                              who, rd, e.who, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        checks = 0;
        passed = 0;
        reset  = 1'b1;
        inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd0;
        inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
        data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd0;
        data_if.addr = 32'h0; data_if.wdata = 32'h0;
        mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'h0;
        repeat (2) nxt();
        smp();
        chk1("rst_mem_req", mem_if.req, 1'b0);
        chk1("rst_mem_wr", mem_if.wr, 1'b0);
        chk("rst_mem_size", {30'd0, mem_if.size}, 32'd0);
        chk("rst_mem_addr", mem_if.addr, 32'h0);
        chk("rst_mem_wdata", mem_if.wdata, 32'h0);
        nxt();
        reset = 1'b0;

        // Lone instruction fetch, minimum latency
        inst_if.req = 1'b1; inst_if.wr = 1'b0; inst_if.size = 2'd2; inst_if.addr = 32'hbfc00000;
        smp();
        chk1("t1_inst_addr_ok", inst_if.addr_ok, 1'b1);
        chk1("t1_data_addr_ok", data_if.addr_ok, 1'b0);
        exp_q.push_back('{who: 1'b0, rdata: 32'h3c080001});
        nxt();
        inst_if.req = 1'b0;
        mem_if.addr_ok = 1'b1;
        smp();
        chk1("t1_mem_req", mem_if.req, 1'b1);
        chk("t1_mem_addr", mem_if.addr, 32'hbfc00000);
        chk1("t1_mem_wr", mem_if.wr, 1'b0);
        chk("t1_mem_size", {30'd0, mem_if.size}, 32'd2);
        nxt();
        mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'h3c080001;
        smp();
        nxt();
        mem_if.data_ok = 1'b0;
        smp();
        chk1("t1_idle_mem_req", mem_if.req, 1'b0);

        // Stray responses in IDLE are ignored
        nxt();
        mem_if.data_ok = 1'b1; mem_if.addr_ok = 1'b1; mem_if.rdata = 32'hdeadbeef;
        smp();
        chk1("stray_inst_data_ok", inst_if.data_ok, 1'b0);
        chk1("stray_data_data_ok", data_if.data_ok, 1'b0);
        nxt();
        mem_if.data_ok = 1'b0; mem_if.addr_ok = 1'b0;
        smp();
        chk1("stray_mem_req", mem_if.req, 1'b0);

        // Simultaneous requests: data write wins, slave stalls addr_ok five cycles
        nxt();
        data_if.req = 1'b1; data_if.wr = 1'b1; data_if.size = 2'd2;
        data_if.addr = 32'h80000010; data_if.wdata = 32'h12345678;
        inst_if.req = 1'b1; inst_if.wr = 1'b0; inst_if.size = 2'd2; inst_if.addr = 32'hbfc00004;
        smp();
        chk1("t2_data_addr_ok", data_if.addr_ok, 1'b1);
        chk1("t2_inst_addr_ok", inst_if.addr_ok, 1'b0);
        exp_q.push_back('{who: 1'b1, rdata: 32'h00000000});
        nxt();
        data_if.req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk1("stall_mem_req", mem_if.req, 1'b1);
            chk1("stall_mem_wr", mem_if.wr, 1'b1);
            chk("stall_mem_addr", mem_if.addr, 32'h80000010);
            chk("stall_mem_wdata", mem_if.wdata, 32'h12345678);
            chk1("stall_inst_addr_ok", inst_if.addr_ok, 1'b0);
            nxt();
            mem_if.data_ok = (i == 2) ? 1'b1 : 1'b0;
        end
        mem_if.addr_ok = 1'b1;
        smp();
        chk1("t2_still_addr", mem_if.req, 1'b1);
        nxt();
        mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'h00000000;
        smp();
        chk1("t2_data_no_accept", inst_if.addr_ok, 1'b0);
        nxt();
        mem_if.data_ok = 1'b0;
        smp();
        chk1("t2_inst_addr_ok_late", inst_if.addr_ok, 1'b1);
        exp_q.push_back('{who: 1'b0, rdata: 32'h0000aaaa});
        nxt();
        inst_if.req = 1'b0;
        mem_if.addr_ok = 1'b1;
        smp();
        chk("t2_inst_mem_addr", mem_if.addr, 32'hbfc00004);
        chk1("t2_inst_mem_wr", mem_if.wr, 1'b0);
        nxt();
        mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0000aaaa;
        smp();
        nxt();
        mem_if.data_ok = 1'b0;

        // Reset while in DATA drops the response
        data_if.req = 1'b1; data_if.wr = 1'b0; data_if.addr = 32'h80000020; data_if.wdata = 32'h55aa55aa;
        smp();
        chk1("t3_data_addr_ok", data_if.addr_ok, 1'b1);
        nxt();
        data_if.req = 1'b0;
        mem_if.addr_ok = 1'b1;
        smp();
        nxt();
        mem_if.addr_ok = 1'b0;
        reset = 1'b1;
        smp();
        nxt();
        smp();
        chk1("t3_rst_mem_req", mem_if.req, 1'b0);
        chk1("t3_rst_mem_wr", mem_if.wr, 1'b0);
        chk("t3_rst_mem_size", {30'd0, mem_if.size}, 32'd0);
        chk("t3_rst_mem_addr", mem_if.addr, 32'h0);
        chk("t3_rst_mem_wdata", mem_if.wdata, 32'h0);
        nxt();
        reset = 1'b0;
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'hbadbad00;
        smp();
        chk1("t3_stray_data_ok", data_if.data_ok, 1'b0);
        chk1("t3_stray_inst_ok", inst_if.data_ok, 1'b0);
        nxt();
        mem_if.data_ok = 1'b0;

        // Both held continuously for four transactions
        for (int k = 0; k < 4; k++) run_both(k);
        inst_if.req = 1'b0;
        data_if.req = 1'b0;
        nxt();
        smp();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
